// File: rtl/soc_lsu_pkg.sv
// rtl/soc_lsu_pkg.sv - shared size, cause and state codes for the load/store unit
// Purpose: common definitions imported by the LSU, its align helper and its bench.
// Ports: none (package).
package soc_lsu_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;
  localparam logic [1:0] LSU_SIZE_X = 2'b11;

  localparam logic [1:0] LSU_CAUSE_NONE     = 2'b00;
  localparam logic [1:0] LSU_CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] LSU_CAUSE_SIZE     = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2
  } lsu_state_e;

  // Request fields kept across ACCESS; the fault verdict is decided at accept.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic       fault;
    logic [1:0] cause;
  } lsu_req_t;

endpackage

// File: rtl/soc_lsu_if.sv
// rtl/soc_lsu_if.sv - request, response and datamem signals of the load/store unit
// Purpose: bundles the core-side request/response handshakes and the datamem port.
// Modports: slave = LSU view, master = core/memory view.
interface soc_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [1:0]  rsp_cause;

  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_cause,
    output mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_cause,
    input  mem_wen, mem_addr, mem_wdata
  );

endinterface

// File: rtl/soc_lsu_align.sv
// rtl/soc_lsu_align.sv - byte enables, access length and load extension by size
// Purpose: purely combinational size decode shared by the LSU datapath.
// Ports: size/is_unsigned/rdata in; wen (byte lanes), nbytes (access length), ext (extended load data) out.
module soc_lsu_align
  import soc_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  output logic [3:0]  wen,
  output logic [2:0]  nbytes,
  output logic [31:0] ext
);

  always_comb begin
    wen    = 4'b0000;
    nbytes = 3'd0;
    ext    = 32'd0;
    case (size)
      LSU_SIZE_B: begin
        wen    = 4'b0001;
        nbytes = 3'd1;
        ext    = {{24{~is_unsigned & rdata[7]}}, rdata[7:0]};
      end
      LSU_SIZE_H: begin
        wen    = 4'b0011;
        nbytes = 3'd2;
        ext    = {{16{~is_unsigned & rdata[15]}}, rdata[15:0]};
      end
      LSU_SIZE_W: begin
        wen    = 4'b1111;
        nbytes = 3'd4;
        ext    = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/soc_lsu.sv
// rtl/soc_lsu.sv - load/store unit between the memory stage and datamem
// Purpose: accepts one request per handshake, range/size/alignment checks it, drives
//   the datamem byte-lane port for one ACCESS cycle and returns a registered response.
// Ports: clk, rst_n (async, active low); lsu (soc_lsu_if.slave) carrying
//   req_* (request handshake), rsp_* (response handshake), mem_* (datamem port).
module soc_lsu
  import soc_lsu_pkg::*;
#(
  parameter logic [31:0] DATA_BASE        = 32'h0000_0000,
  parameter int unsigned MEM_SIZE         = 4096,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input logic      clk,
  input logic      rst_n,
  soc_lsu_if.slave lsu
);

  localparam logic [32:0] LAST_ADDR = {1'b0, DATA_BASE} + 33'(MEM_SIZE) - 33'd1;

  lsu_state_e  state, state_nxt;
  lsu_req_t    req_q;
  logic        accept;
  logic [1:0]  al_size;
  logic [3:0]  al_wen;
  logic [2:0]  al_nbytes;
  logic [31:0] al_ext;
  logic [32:0] addr_off;
  logic [32:0] req_end;
  logic        range_bad;
  logic        misaligned;
  logic [1:0]  cause;

  // One decoder serves both phases: the incoming size while accepting (for the
  // range check), the captured size during ACCESS (for lanes and extension).
  assign al_size = (state == LSU_ACCESS) ? req_q.size : lsu.req_size;

  soc_lsu_align u_align (
    .size        (al_size),
    .is_unsigned (req_q.uns),
    .rdata       (lsu.mem_rdata),
    .wen         (al_wen),
    .nbytes      (al_nbytes),
    .ext         (al_ext)
  );

  // 33-bit arithmetic: a borrow means below the window, a carry past 2^32 lands
  // above LAST_ADDR, so both wrap directions read as out of range.
  assign addr_off  = {1'b0, lsu.req_addr} - {1'b0, DATA_BASE};
  assign req_end   = {1'b0, lsu.req_addr} + {30'd0, al_nbytes} - 33'd1;
  assign range_bad = addr_off[32] || (req_end > LAST_ADDR);

  assign misaligned = !ALLOW_MISALIGNED &&
                      (((lsu.req_size == LSU_SIZE_H) && lsu.req_addr[0]) ||
                       ((lsu.req_size == LSU_SIZE_W) && (lsu.req_addr[1:0] != 2'b00)));

  always_comb begin
    if (lsu.req_size == LSU_SIZE_X) cause = LSU_CAUSE_SIZE;
    else if (range_bad)             cause = LSU_CAUSE_RANGE;
    else if (misaligned)            cause = LSU_CAUSE_MISALIGN;
    else                            cause = LSU_CAUSE_NONE;
  end

  assign accept = lsu.req_valid && lsu.req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LSU_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE:   if (lsu.req_valid) state_nxt = LSU_ACCESS;
      LSU_ACCESS: state_nxt = LSU_RESP;
      LSU_RESP:   if (lsu.rsp_ready) state_nxt = lsu.req_valid ? LSU_ACCESS : LSU_IDLE;
      default:    state_nxt = LSU_IDLE;
    endcase
  end

  // req_ready depends on state and rsp_ready only, so a requester may wait on it.
  always_comb begin
    lsu.req_ready = 1'b0;
    lsu.rsp_valid = 1'b0;
    lsu.mem_wen   = 4'b0000;
    case (state)
      LSU_IDLE:   lsu.req_ready = 1'b1;
      LSU_ACCESS: if (req_q.we && !req_q.fault) lsu.mem_wen = al_wen;
      LSU_RESP: begin
        lsu.rsp_valid = 1'b1;
        lsu.req_ready = lsu.rsp_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q         <= '0;
      lsu.mem_addr  <= 32'd0;
      lsu.mem_wdata <= 32'd0;
      lsu.rsp_rdata <= 32'd0;
      lsu.rsp_fault <= 1'b0;
      lsu.rsp_cause <= LSU_CAUSE_NONE;
    end else begin
      if (accept) begin
        req_q.we      <= lsu.req_we;
        req_q.size    <= lsu.req_size;
        req_q.uns     <= lsu.req_unsigned;
        req_q.fault   <= (cause != LSU_CAUSE_NONE);
        req_q.cause   <= cause;
        // Loaded here so they are valid for the whole ACCESS cycle and then hold.
        lsu.mem_addr  <= addr_off[31:0];
        lsu.mem_wdata <= lsu.req_wdata;
      end
      if (state == LSU_ACCESS) begin
        lsu.rsp_rdata <= (req_q.we || req_q.fault) ? 32'd0 : al_ext;
        lsu.rsp_fault <= req_q.fault;
        lsu.rsp_cause <= req_q.cause;
      end
    end
  end

endmodule

// File: tb/tb_soc_lsu.sv
// tb/tb_soc_lsu.sv - self-checking bench for soc_lsu with a byte-array datamem model
module tb_soc_lsu;
  import soc_lsu_pkg::*;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          MSIZE = 4096;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  cause;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  soc_lsu_if bus ();
  soc_lsu_if sbus ();

  soc_lsu #(.DATA_BASE(BASE), .MEM_SIZE(MSIZE), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .lsu(bus)
  );
  soc_lsu #(.DATA_BASE(BASE), .MEM_SIZE(MSIZE), .ALLOW_MISALIGNED(1'b0)) dut_strict (
    .clk(clk), .rst_n(rst_n), .lsu(sbus)
  );

  assign sbus.req_valid    = bus.req_valid;
  assign sbus.req_we       = bus.req_we;
  assign sbus.req_size     = bus.req_size;
  assign sbus.req_unsigned = bus.req_unsigned;
  assign sbus.req_addr     = bus.req_addr;
  assign sbus.req_wdata    = bus.req_wdata;
  assign sbus.rsp_ready    = bus.rsp_ready;

  logic [7:0] mem  [0:MSIZE-1] = '{default: 8'h00};
  logic [7:0] smem [0:MSIZE-1] = '{default: 8'h00};

  function automatic int unsigned midx(input logic [31:0] a, input int k);
    return int'((a + 32'(k)) & 32'(MSIZE - 1));
  endfunction

  assign bus.mem_rdata  = {mem[midx(bus.mem_addr, 3)], mem[midx(bus.mem_addr, 2)],
                           mem[midx(bus.mem_addr, 1)], mem[midx(bus.mem_addr, 0)]};
  assign sbus.mem_rdata = {smem[midx(sbus.mem_addr, 3)], smem[midx(sbus.mem_addr, 2)],
                           smem[midx(sbus.mem_addr, 1)], smem[midx(sbus.mem_addr, 0)]};

  int          wen_cycles  = 0;
  int          full_cycles = 0;
  logic [3:0]  last_wen    = 4'b0000;
  logic [31:0] last_waddr  = 32'd0;

  always @(posedge clk) begin
    if (bus.mem_wen != 4'b0000) begin
      wen_cycles <= wen_cycles + 1;
      last_wen   <= bus.mem_wen;
      last_waddr <= bus.mem_addr;
    end
    if (bus.mem_wen == 4'b1111) full_cycles <= full_cycles + 1;
    for (int k = 0; k < 4; k++) begin
      if (bus.mem_wen[k])  mem[midx(bus.mem_addr, k)]   <= bus.mem_wdata[8*k +: 8];
      if (sbus.mem_wen[k]) smem[midx(sbus.mem_addr, k)] <= sbus.mem_wdata[8*k +: 8];
    end
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  rsp_t exp_q[$];
  rsp_t sexp_q[$];
  rsp_t mon_e, mon_se;

  function automatic rsp_t mk(input logic [31:0] rdata, input logic fault, input logic [1:0] cause);
    rsp_t r;
    r.rdata = rdata;
    r.fault = fault;
    r.cause = cause;
    return r;
  endfunction

  // Scoreboard: a response is popped on the cycle its handshake completes.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      n_checks++;
      if (exp_q.size() == 0 || sexp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp got rdata=%h fault=%b cause=%b required=no response",
                 bus.rsp_rdata, bus.rsp_fault, bus.rsp_cause);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_se = sexp_q.pop_front();
        if ({bus.rsp_rdata, bus.rsp_fault, bus.rsp_cause} !== mon_e) begin
          n_fail++;
          $display("FAIL rsp got rdata=%h fault=%b cause=%b required rdata=%h fault=%b cause=%b",
                   bus.rsp_rdata, bus.rsp_fault, bus.rsp_cause, mon_e.rdata, mon_e.fault, mon_e.cause);
        end
        n_checks++;
        if ({sbus.rsp_valid, sbus.rsp_rdata, sbus.rsp_fault, sbus.rsp_cause} !== {1'b1, mon_se}) begin
          n_fail++;
          $display("FAIL strict_rsp got valid=%b rdata=%h fault=%b cause=%b required valid=1 rdata=%h fault=%b cause=%b",
                   sbus.rsp_valid, sbus.rsp_rdata, sbus.rsp_fault, sbus.rsp_cause,
                   mon_se.rdata, mon_se.fault, mon_se.cause);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input rsp_t e, input rsp_t se);
    int n = 0;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (!bus.req_ready) begin
      n_fail++;
      $display("FAIL accept_timeout addr=%h got req_ready=%b required=1", addr, bus.req_ready);
    end else begin
      exp_q.push_back(e);
      sexp_q.push_back(se);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rsp_timeout got pending=%0d required=0", exp_q.size());
      exp_q.delete();
      sexp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = LSU_SIZE_B; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready got=%b required=1", bus.req_ready);
    end
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_fault, bus.rsp_cause} !== 36'd0) begin
      n_fail++; $display("FAIL reset_rsp got valid=%b rdata=%h fault=%b cause=%b required all 0",
                         bus.rsp_valid, bus.rsp_rdata, bus.rsp_fault, bus.rsp_cause);
    end
    n_checks++;
    if ({bus.mem_wen, bus.mem_addr, bus.mem_wdata} !== 68'd0) begin
      n_fail++; $display("FAIL reset_mem got wen=%b addr=%h wdata=%h required all 0",
                         bus.mem_wen, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_word_store_load();
    int f0 = full_cycles;
    issue(1'b1, LSU_SIZE_W, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF, mk(32'd0, 1'b0, 2'b00), mk(32'd0, 1'b0, 2'b00));
    drain();
    n_checks++;
    if (full_cycles - f0 !== 1) begin
      n_fail++; $display("FAIL sw_wen_cycles got=%0d required=1", full_cycles - f0);
    end
    n_checks++;
    if ({mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10], last_waddr} !== {32'hDEAD_BEEF, 32'h10}) begin
      n_fail++; $display("FAIL sw_mem got data=%h addr=%h required data=deadbeef addr=00000010",
                         {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]}, last_waddr);
    end
    issue(1'b0, LSU_SIZE_W, 1'b0, BASE + 32'h10, 32'd0, mk(32'hDEAD_BEEF, 1'b0, 2'b00), mk(32'hDEAD_BEEF, 1'b0, 2'b00));
    drain();
  endtask

  task automatic test_extend();
    issue(1'b1, LSU_SIZE_W, 1'b0, BASE + 32'h20, 32'h0000_80F0, mk(32'd0, 1'b0, 2'b00), mk(32'd0, 1'b0, 2'b00));
    issue(1'b0, LSU_SIZE_B, 1'b0, BASE + 32'h20, 32'd0, mk(32'hFFFF_FFF0, 1'b0, 2'b00), mk(32'hFFFF_FFF0, 1'b0, 2'b00));
    issue(1'b0, LSU_SIZE_B, 1'b1, BASE + 32'h20, 32'd0, mk(32'h0000_00F0, 1'b0, 2'b00), mk(32'h0000_00F0, 1'b0, 2'b00));
    issue(1'b0, LSU_SIZE_H, 1'b0, BASE + 32'h20, 32'd0, mk(32'hFFFF_80F0, 1'b0, 2'b00), mk(32'hFFFF_80F0, 1'b0, 2'b00));
    issue(1'b0, LSU_SIZE_H, 1'b1, BASE + 32'h20, 32'd0, mk(32'h0000_80F0, 1'b0, 2'b00), mk(32'h0000_80F0, 1'b0, 2'b00));
    drain();
  endtask

  task automatic test_range();
    int w0 = wen_cycles;
    issue(1'b0, LSU_SIZE_W, 1'b0, BASE + MSIZE - 2, 32'd0, mk(32'd0, 1'b1, 2'b10), mk(32'd0, 1'b1, 2'b10));
    issue(1'b1, LSU_SIZE_W, 1'b0, 32'hFFFF_FFFE, 32'h1234_5678, mk(32'd0, 1'b1, 2'b10), mk(32'd0, 1'b1, 2'b10));
    issue(1'b1, LSU_SIZE_X, 1'b0, BASE + 32'h10, 32'h1234_5678, mk(32'd0, 1'b1, 2'b11), mk(32'd0, 1'b1, 2'b11));
    issue(1'b1, LSU_SIZE_B, 1'b0, BASE - 1, 32'h0000_0055, mk(32'd0, 1'b1, 2'b10), mk(32'd0, 1'b1, 2'b10));
    drain();
    n_checks++;
    if (wen_cycles - w0 !== 0) begin
      n_fail++; $display("FAIL fault_wen_cycles got=%0d required=0", wen_cycles - w0);
    end
    issue(1'b1, LSU_SIZE_B, 1'b0, BASE + MSIZE - 1, 32'h0000_0080, mk(32'd0, 1'b0, 2'b00), mk(32'd0, 1'b0, 2'b00));
    issue(1'b0, LSU_SIZE_B, 1'b0, BASE + MSIZE - 1, 32'd0, mk(32'hFFFF_FF80, 1'b0, 2'b00), mk(32'hFFFF_FF80, 1'b0, 2'b00));
    drain();
  endtask

  task automatic test_misalign();
    issue(1'b1, LSU_SIZE_H, 1'b0, BASE + 32'h31, 32'h0000_1234, mk(32'd0, 1'b0, 2'b00), mk(32'd0, 1'b1, 2'b01));
    drain();
    n_checks++;
    if ({last_wen, last_waddr} !== {4'b0011, 32'h31}) begin
      n_fail++; $display("FAIL sh_lanes got wen=%b addr=%h required wen=0011 addr=00000031", last_wen, last_waddr);
    end
    n_checks++;
    if ({mem[16'h32], mem[16'h31], smem[16'h32], smem[16'h31]} !== 32'h1234_0000) begin
      n_fail++; $display("FAIL sh_mem got main=%h strict=%h required main=1234 strict=0000",
                         {mem[16'h32], mem[16'h31]}, {smem[16'h32], smem[16'h31]});
    end
    issue(1'b0, LSU_SIZE_H, 1'b1, BASE + 32'h31, 32'd0, mk(32'h0000_1234, 1'b0, 2'b00), mk(32'd0, 1'b1, 2'b01));
    drain();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    bus.rsp_ready = 1'b0;
    issue(1'b0, LSU_SIZE_W, 1'b0, BASE + 32'h10, 32'd0, mk(32'hDEAD_BEEF, 1'b0, 2'b00), mk(32'hDEAD_BEEF, 1'b0, 2'b00));
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = LSU_SIZE_W; bus.req_unsigned = 1'b0;
    bus.req_addr = BASE + 32'h20; bus.req_wdata = 32'd0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_fault, bus.rsp_cause} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 2'b00}) begin
        n_fail++; $display("FAIL hold_rsp cycle=%0d got valid=%b rdata=%h fault=%b cause=%b required valid=1 rdata=deadbeef fault=0 cause=00",
                           i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_fault, bus.rsp_cause);
      end
      n_checks++;
      if (bus.req_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_req_ready cycle=%0d got=%b required=0", i, bus.req_ready);
      end
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_req_ready got=%b required=1", bus.req_ready);
    end else begin
      exp_q.push_back(mk(32'h0000_80F0, 1'b0, 2'b00));
      sexp_q.push_back(mk(32'h0000_80F0, 1'b0, 2'b00));
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_gap got rsp_valid=%b required=0", bus.rsp_valid);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_latency got rsp_valid=%b required=1", bus.rsp_valid);
    end
    drain();
  endtask

  task automatic test_reset_mid_store();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = LSU_SIZE_B; bus.req_unsigned = 1'b0;
    bus.req_addr = BASE + 32'h40; bus.req_wdata = 32'h0000_00AA;
    @(negedge clk);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.mem_wen !== 4'b0001) begin
      n_fail++; $display("FAIL sb_access_wen got=%b required=0001", bus.mem_wen);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_fault, bus.rsp_cause, bus.mem_wen, bus.mem_addr, bus.mem_wdata} !== 104'd0) begin
      n_fail++; $display("FAIL midreset_outputs got valid=%b rdata=%h fault=%b cause=%b wen=%b addr=%h wdata=%h required all 0",
                         bus.rsp_valid, bus.rsp_rdata, bus.rsp_fault, bus.rsp_cause, bus.mem_wen, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL midreset_release got req_ready=%b rsp_valid=%b required req_ready=1 rsp_valid=0",
                         bus.req_ready, bus.rsp_valid);
    end
    n_checks++;
    if ({mem[16'h40], smem[16'h40]} !== 16'h0000) begin
      n_fail++; $display("FAIL midreset_mem got main=%h strict=%h required 00 00", mem[16'h40], smem[16'h40]);
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_extend();
    test_range();
    test_misalign();
    test_back_to_back();
    test_reset_mid_store();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL leftover_rsp got pending=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got time=%0t required finish earlier", $time);
    $fatal(1);
  end

endmodule
